nrzi_rx_decoder: RTL

NRZI_RX_DECODER -- requirements
Module: nrzi_rx_decoder

---
 rtl/nrzi_pkg.sv | 11 +
 rtl/t_to_d_bit.sv | 32 +++
 rtl/nrzi_rx_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI receive path.
package nrzi_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_e;

  localparam logic [7:0] FLAG_DEFAULT = 8'h7E;

endpackage

// File: rtl/t_to_d_bit.sv
// Toggle-to-level cell: decodes one toggle-encoded line sample per enabled cycle.
module t_to_d_bit #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic line_i,
  output logic bit_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = prev_q;
    if (en_i) begin
      prev_d = line_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= IDLE_LEVEL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign bit_o = line_i ^ prev_q;

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receiver: hunts for the frame flag, then delivers decoded bytes over a
// valid/ready handshake until the closing flag.
module nrzi_rx_decoder
  import nrzi_pkg::*;
#(
  parameter logic [7:0] FLAG       = FLAG_DEFAULT,
  parameter logic       IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_line,
  input  logic       in_en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       eof,
  output logic       in_frame,
  output logic       overflow
);

  state_e      state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        eof_q, eof_d;
  logic        ovf_q, ovf_d;

  logic        bit_dec;
  logic [7:0]  shifted;
  logic        flag_hit;
  logic        byte_done;
  logic        close;
  logic        deliver;

  t_to_d_bit #(
    .IDLE_LEVEL(IDLE_LEVEL)
  ) u_t_to_d (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (in_en),
    .line_i(in_line),
    .bit_o (bit_dec)
  );

  // One shift register serves both the flag hunt and byte assembly.
  assign shifted   = {bit_dec, sh_q[7:1]};
  assign flag_hit  = in_en && (state_q == HUNT) && (shifted == FLAG);
  assign byte_done = in_en && (state_q == DATA) && (cnt_q == 3'd7);
  assign close     = byte_done && (shifted == FLAG);
  assign deliver   = byte_done && (shifted != FLAG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (flag_hit) state_d = DATA;
      DATA:    if (close)    state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    in_frame = (state_q == DATA);
  end

  always_comb begin
    sh_d = sh_q;
    if (in_en) begin
      sh_d = shifted;
    end
    if (close) begin
      sh_d = '0;
    end

    cnt_d = cnt_q;
    if (flag_hit) begin
      cnt_d = '0;
    end else if (in_en && (state_q == DATA)) begin
      cnt_d = cnt_q + 3'd1;
    end

    // A completing byte may reuse the slot freed by this cycle's handshake.
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || out_ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    eof_d = close;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign eof       = eof_q;
  assign overflow  = ovf_q;

endmodule
